sfx_tone_mixer: RTL and testbench
=================================

SFX_TONE_MIXER -- requirements
Module: sfx_tone_mixer

Interface
REQ-001: Parameter NUM_SFX, default 4; number of independent square-wave sound-effect channels (1..8).
REQ-002: Parameter HP_W, default 19; width of each half-period value, in CLOCK_50 cycles.
REQ-003: Parameter DUR_W, default 26; width of each duration value, in CLOCK_50 cycles.
REQ-004: Parameter AMPLITUDE, default 10000000; per-channel square-wave magnitude, signed 32-bit, positive.
REQ-005: CLOCK_50  input  1  sole clock, all state on its rising edge.
REQ-006: reset  input  1  asynchronous, active-high reset.
REQ-007: sfx_trigger  input  NUM_SFX  one-cycle start pulse per channel.
REQ-008: sfx_half_period  input  NUM_SFX*HP_W  per-channel half period; channel i occupies bits [i*HP_W +: HP_W].
REQ-009: sfx_duration  input  NUM_SFX*DUR_W  per-channel play length; channel i occupies bits [i*DUR_W +: DUR_W].
REQ-010: audio_in_available  input  1  codec input FIFO holds a sample.
REQ-011: audio_out_allowed  input  1  codec output FIFO has space.
REQ-012: left_channel_audio_in, right_channel_audio_in  input  32 each  signed microphone samples.
REQ-013: read_audio_in  output  1  pop codec input FIFO.
REQ-014: write_audio_out  output  1  push codec output FIFO.
REQ-015: left_channel_audio_out, right_channel_audio_out  output  32 each  signed mixed samples.
REQ-016: sfx_active  output  NUM_SFX  channel i currently playing.
REQ-017: busy  output  1  OR of sfx_active.

Function
REQ-018: Each channel has an FSM with states IDLE and PLAY, plus a half-period counter, a duration counter, and a phase bit.
REQ-019: IDLE -> PLAY on a trigger when the duration input is nonzero: capture half-period and duration, clear both counters, set phase=1; sfx_active rises on the next cycle.
REQ-020: A trigger with duration 0 is ignored; the channel stays IDLE.
REQ-021: A trigger in PLAY restarts the channel with the newly sampled values; the channel does not pass through IDLE.
REQ-022: In PLAY, the phase toggles when the half-period counter equals the captured half period; the counter then returns to 0. Otherwise the counter increments. This gives a tone period of 2*(HP+1) cycles.
REQ-023: Captured half period 0 means a silent channel: contribution 0, but the duration still runs and sfx_active stays high.
REQ-024: PLAY -> IDLE when the duration counter reaches the captured duration minus 1. A channel therefore plays for exactly D cycles.
REQ-025: Contribution of a PLAY channel is +AMPLITUDE when phase=1 and -AMPLITUDE when phase=0. Contribution of an IDLE channel is 0.
REQ-026: Mix = signed sum of all contributions, computed at 32+clog2(NUM_SFX)+1 bits, saturated to signed 32 bits, and registered into mix_r every cycle. Latency is trigger -> first nonzero mix_r in 2 cycles.
REQ-027: left/right out = saturate32(left/right in + mix_r). This path is combinational. Both channels receive the same mix_r.
REQ-028: read_audio_in = write_audio_out = audio_in_available & audio_out_allowed. Both are combinational. No write occurs without a read.
REQ-029: If one input of the handshake is low, neither strobe asserts, and the FSMs and counters continue unaffected.
REQ-030: Triggers on several channels in the same cycle all start independently.

Reset
REQ-031: On reset assertion, asynchronously: all channels go IDLE, all counters and phase bits clear, mix_r=0, sfx_active=0, busy=0.
REQ-032: Reset mid-play silences output from the assertion onward. Audio outputs equal the inputs while reset is held.
REQ-033: After deassertion, a trigger is honoured no earlier than the first rising edge with reset low.

Configuration
REQ-034: Macro SFX_MIC_PASSTHROUGH_EN defined: outputs behave as in REQ-027.
REQ-035: Macro SFX_MIC_PASSTHROUGH_EN undefined: outputs = mix_r only, and microphone inputs are ignored. The handshake of REQ-028 is unchanged, so the input FIFO still drains.

Verification
REQ-036: NUM_SFX=4, ch0 HP=3 D=16, inputs 0 -> ch0 active for exactly 16 cycles. mix_r sequence is +1e7 x4, -1e7 x4, repeating. Returns to 0 after the 16 cycles.
REQ-037: All 4 channels triggered together, HP=5, AMPLITUDE=1e9 -> mix_r saturates at 2147483647. Opposite-phase case gives 0 where expected.
REQ-038: ch1 retriggered at cycle 10 of D=20 -> stays active to cycle 30. The counters restart, and sfx_active never drops.
REQ-039: audio_in_available=1, audio_out_allowed toggling; left_in=-2147483000, mix=-1e7 -> strobes only when both inputs are high; output clamps to -2147483648.
REQ-040: reset pulse during play -> sfx_active=0, busy=0 and mix_r=0 within the same cycle. A duration-0 trigger after reset produces no activity.
REQ-041: Build without SFX_MIC_PASSTHROUGH_EN, left_in=12345, no triggers -> left_out=0 and read_audio_in still asserts with the handshake.

Source files
------------

// File: rtl/sfx_tone_mixer.sv
// sfx_tone_mixer: NUM_SFX square-wave effect channels mixed into the codec audio stream.
// Define SFX_MIC_PASSTHROUGH_EN to add the mix on top of the microphone input; otherwise only the mix is played.

module sfx_channel #(
  parameter int                 HP_W      = 19,
  parameter int                 DUR_W     = 26,
  parameter logic signed [31:0] AMPLITUDE = 32'sd10000000
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               trigger,
  input  logic [HP_W-1:0]    half_period,
  input  logic [DUR_W-1:0]   duration,
  output logic               active,
  output logic signed [31:0] contrib
);
  typedef enum logic {IDLE, PLAY} state_t;
  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } cfg_t;

  state_t           state, state_n;
  cfg_t             cfg, cfg_n;
  logic [HP_W-1:0]  hp_cnt, hp_cnt_n;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_n;
  logic             phase, phase_n;
  logic             start;

  // a zero-length trigger is dropped in either state
  assign start = trigger && (duration != '0);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cfg     <= '0;
      hp_cnt  <= '0;
      dur_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      state   <= state_n;
      cfg     <= cfg_n;
      hp_cnt  <= hp_cnt_n;
      dur_cnt <= dur_cnt_n;
      phase   <= phase_n;
    end
  end

  always_comb begin
    state_n   = state;
    cfg_n     = cfg;
    hp_cnt_n  = hp_cnt;
    dur_cnt_n = dur_cnt;
    phase_n   = phase;
    if (start) begin
      state_n   = PLAY;
      cfg_n.hp  = half_period;
      cfg_n.dur = duration;
      hp_cnt_n  = '0;
      dur_cnt_n = '0;
      phase_n   = 1'b1;
    end else if (state == PLAY) begin
      if (dur_cnt == cfg.dur - DUR_W'(1)) begin
        state_n   = IDLE;
        hp_cnt_n  = '0;
        dur_cnt_n = '0;
        phase_n   = 1'b0;
      end else begin
        dur_cnt_n = dur_cnt + DUR_W'(1);
        if (hp_cnt == cfg.hp) begin
          phase_n  = ~phase;
          hp_cnt_n = '0;
        end else begin
          hp_cnt_n = hp_cnt + HP_W'(1);
        end
      end
    end
  end

  assign active  = (state == PLAY);
  assign contrib = (state == PLAY && cfg.hp != '0) ? (phase ? AMPLITUDE : -AMPLITUDE) : 32'sd0;
endmodule

module sfx_tone_mixer #(
  parameter int                 NUM_SFX   = 4,
  parameter int                 HP_W      = 19,
  parameter int                 DUR_W     = 26,
  parameter logic signed [31:0] AMPLITUDE = 32'sd10000000
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [NUM_SFX-1:0]       sfx_trigger,
  input  logic [NUM_SFX*HP_W-1:0]  sfx_half_period,
  input  logic [NUM_SFX*DUR_W-1:0] sfx_duration,
  input  logic                     audio_in_available,
  input  logic                     audio_out_allowed,
  input  logic signed [31:0]       left_channel_audio_in,
  input  logic signed [31:0]       right_channel_audio_in,
  output logic                     read_audio_in,
  output logic                     write_audio_out,
  output logic signed [31:0]       left_channel_audio_out,
  output logic signed [31:0]       right_channel_audio_out,
  output logic [NUM_SFX-1:0]       sfx_active,
  output logic                     busy
);
  localparam int SUM_W = 32 + $clog2(NUM_SFX) + 1;

  logic [NUM_SFX-1:0][31:0] contrib;
  logic signed [SUM_W-1:0]  mix_sum;
  logic [SUM_W-32:0]        mix_top;
  logic signed [31:0]       mix_sat, mix_r;

  for (genvar i = 0; i < NUM_SFX; i++) begin : g_ch
    sfx_channel #(
      .HP_W      (HP_W),
      .DUR_W     (DUR_W),
      .AMPLITUDE (AMPLITUDE)
    ) u_ch (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .trigger     (sfx_trigger[i]),
      .half_period (sfx_half_period[i*HP_W +: HP_W]),
      .duration    (sfx_duration[i*DUR_W +: DUR_W]),
      .active      (sfx_active[i]),
      .contrib     (contrib[i])
    );
  end

  // the sum fits in 32 bits only when all bits from 31 upward agree
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_SFX; i++) mix_sum = mix_sum + SUM_W'($signed(contrib[i]));
    mix_top = mix_sum[SUM_W-1:31];
    if (&mix_top || ~|mix_top) mix_sat = mix_sum[31:0];
    else                       mix_sat = mix_top[SUM_W-32] ? 32'sh80000000 : 32'sh7fffffff;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) mix_r <= '0;
    else       mix_r <= mix_sat;
  end

  assign busy            = |sfx_active;
  assign read_audio_in   = audio_in_available & audio_out_allowed;
  assign write_audio_out = read_audio_in;

`ifdef SFX_MIC_PASSTHROUGH_EN
  function automatic logic signed [31:0] sat33(input logic signed [32:0] v);
    if (v[32] != v[31]) return v[32] ? 32'sh80000000 : 32'sh7fffffff;
    return v[31:0];
  endfunction

  assign left_channel_audio_out  = sat33({left_channel_audio_in[31], left_channel_audio_in} + {mix_r[31], mix_r});
  assign right_channel_audio_out = sat33({right_channel_audio_in[31], right_channel_audio_in} + {mix_r[31], mix_r});
`else
  // microphone samples are still popped by the handshake but not played
  logic mic_unused;
  assign mic_unused              = ^{left_channel_audio_in, right_channel_audio_in};
  assign left_channel_audio_out  = mix_r;
  assign right_channel_audio_out = mix_r;
`endif
endmodule

// File: tb/tb_sfx_tone_mixer.sv
// Bench for sfx_tone_mixer: closed-form tone schedule model feeding a scoreboard queue,
// table-driven handshake/saturation vectors, and hand-written retrigger/reset sequences.

module tb_sfx_tone_mixer;
  localparam int N   = 4;
  localparam int HPW = 19;
  localparam int DW  = 26;
  localparam logic signed [31:0] AMP = 32'sd1000000000;

  logic                CLOCK_50 = 1'b0;
  logic                reset;
  logic [N-1:0]        sfx_trigger;
  logic [N*HPW-1:0]    sfx_half_period;
  logic [N*DW-1:0]     sfx_duration;
  logic                audio_in_available, audio_out_allowed;
  logic signed [31:0]  left_channel_audio_in, right_channel_audio_in;
  logic                read_audio_in, write_audio_out;
  logic signed [31:0]  left_channel_audio_out, right_channel_audio_out;
  logic [N-1:0]        sfx_active;
  logic                busy;

  sfx_tone_mixer #(.NUM_SFX(N), .HP_W(HPW), .DUR_W(DW), .AMPLITUDE(AMP)) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .sfx_trigger             (sfx_trigger),
    .sfx_half_period         (sfx_half_period),
    .sfx_duration            (sfx_duration),
    .audio_in_available      (audio_in_available),
    .audio_out_allowed       (audio_out_allowed),
    .left_channel_audio_in   (left_channel_audio_in),
    .right_channel_audio_in  (right_channel_audio_in),
    .read_audio_in           (read_audio_in),
    .write_audio_out         (write_audio_out),
    .left_channel_audio_out  (left_channel_audio_out),
    .right_channel_audio_out (right_channel_audio_out),
    .sfx_active              (sfx_active),
    .busy                    (busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    string              nm;
    logic signed [31:0] l, r;
    logic               strobe;
    logic [N-1:0]       act;
  } exp_t;

  typedef struct {
    logic               av, al;
    logic signed [31:0] li, ri;
    logic               exp_rd;
  } hs_t;

  exp_t   sbq[$];
  hs_t    tab[10];
  int     tests = 0, fails = 0;
  int     mcyc;
  int     c0[N], hp_m[N], dur_m[N];
  bit     sch[N];
  longint prev_sum;

  function automatic logic signed [31:0] sat(input longint v);
    if (v > 64'sd2147483647)  return 32'sh7fffffff;
    if (v < -64'sd2147483648) return 32'sh80000000;
    return v[31:0];
  endfunction

  function automatic logic signed [31:0] exp_out(input logic signed [31:0] i, input logic signed [31:0] m);
`ifdef SFX_MIC_PASSTHROUGH_EN
    return sat(longint'(i) + longint'(m));
`else
    return m;
`endif
  endfunction

  task automatic check();
    exp_t e;
    if (sbq.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e = sbq.pop_front();
    tests++;
    if (left_channel_audio_out !== e.l || right_channel_audio_out !== e.r ||
        read_audio_in !== e.strobe || write_audio_out !== e.strobe ||
        sfx_active !== e.act || busy !== (|e.act)) begin
      fails++;
      $display("FAIL %s cyc=%0d: left got %0d want %0d, right got %0d want %0d, rd/wr got %b%b want %b, active got %b want %b, busy got %b want %b",
               e.nm, mcyc, left_channel_audio_out, e.l, right_channel_audio_out, e.r,
               read_audio_in, write_audio_out, e.strobe, sfx_active, e.act, busy, |e.act);
    end
  endtask

  // Channel state after edge k from the trigger cycle alone: active for t=1..D,
  // phase high for the first HP+1 cycles of each 2*(HP+1) period; mix_r lags one edge.
  task automatic step(input logic exp_strobe, input string nm);
    int k; longint s; logic [N-1:0] act; exp_t e; logic signed [31:0] m;
    k = mcyc + 1; s = 0; act = '0;
    for (int i = 0; i < N; i++) begin
      int t;
      t = k - c0[i];
      if (sch[i] && t >= 1 && t <= dur_m[i]) begin
        act[i] = 1'b1;
        if (hp_m[i] != 0) s += ((((t - 1) / (hp_m[i] + 1)) % 2) == 0) ? longint'(AMP) : -longint'(AMP);
      end
    end
    m = sat(prev_sum);
    e.nm = nm; e.l = exp_out(left_channel_audio_in, m); e.r = exp_out(right_channel_audio_in, m);
    e.strobe = exp_strobe; e.act = act;
    sbq.push_back(e);
    prev_sum = s;
    @(negedge CLOCK_50);
    mcyc = k;
    check();
  endtask

  task automatic trig(input int ch, input int hp, input int dur);
    sfx_trigger[ch] = 1'b1;
    sfx_half_period[ch*HPW +: HPW] = HPW'(hp);
    sfx_duration[ch*DW +: DW] = DW'(dur);
    if (dur != 0) begin
      c0[ch] = mcyc; hp_m[ch] = hp; dur_m[ch] = dur; sch[ch] = 1'b1;
    end
  endtask

  // scrambling the config inputs checks that playing channels use captured values
  task automatic untrig();
    sfx_trigger = '0;
    for (int i = 0; i < N; i++) begin
      sfx_half_period[i*HPW +: HPW] = HPW'($urandom);
      sfx_duration[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic apply_row(input int r, input string nm);
    audio_in_available = tab[r].av; audio_out_allowed = tab[r].al;
    left_channel_audio_in = tab[r].li; right_channel_audio_in = tab[r].ri;
    step(tab[r].exp_rd, nm);
  endtask

  task automatic quiet_inputs();
    audio_in_available = 1'b0; audio_out_allowed = 1'b0;
    left_channel_audio_in = '0; right_channel_audio_in = '0;
  endtask

  initial begin
    exp_t e;
    tab[0] = '{1'b1, 1'b1, 32'sd12345, -32'sd77, 1'b1};
    tab[1] = '{1'b1, 1'b0, 32'sd5, 32'sd6, 1'b0};
    tab[2] = '{1'b0, 1'b1, -32'sd5, 32'sd100, 1'b0};
    tab[3] = '{1'b0, 1'b0, 32'sh7fffffff, 32'sh80000000, 1'b0};
    tab[4] = '{1'b1, 1'b1, 32'sd2147483000, 32'sd1000, 1'b1};
    tab[5] = '{1'b0, 1'b1, 32'sh80000000, 32'sd0, 1'b0};
    tab[6] = '{1'b1, 1'b1, -32'sd2147483000, -32'sd2147483000, 1'b1};
    tab[7] = '{1'b1, 1'b0, -32'sd2147483000, 32'sd0, 1'b0};
    tab[8] = '{1'b1, 1'b1, 32'sh7fffffff, -32'sd1147483648, 1'b1};
    tab[9] = '{1'b1, 1'b0, 32'sd0, -32'sd1147483649, 1'b0};

    reset = 1'b1; sfx_trigger = '0; sfx_half_period = '0; sfx_duration = '0;
    quiet_inputs();
    mcyc = 0; prev_sum = 0;
    for (int i = 0; i < N; i++) begin c0[i] = 0; hp_m[i] = 0; dur_m[i] = 0; sch[i] = 1'b0; end

    #5;
    e.nm = "reset_state"; e.l = 32'sd0; e.r = 32'sd0; e.strobe = 1'b0; e.act = '0;
    sbq.push_back(e); check();
    step(1'b0, "reset_hold");
    reset = 1'b0;

    for (int r = 0; r < 4; r++) apply_row(r, "hs_idle");
    quiet_inputs();

    // single tone, HP=3 D=16
    trig(0, 3, 16); step(1'b0, "tone_start"); untrig();
    repeat (19) step(1'b0, "tone_ch0");

    // zero-duration trigger is ignored
    trig(1, 9, 0); step(1'b0, "dur0_trig"); untrig();
    repeat (3) step(1'b0, "dur0_idle");

    // retrigger mid-play at t=10 keeps the channel active 20 more cycles
    trig(1, 2, 20); step(1'b0, "retrig_first"); untrig();
    repeat (9) step(1'b0, "retrig_play");
    trig(1, 4, 20); step(1'b0, "retrig_again"); untrig();
    repeat (23) step(1'b0, "retrig_tail");

    // all four in phase saturate both ways
    for (int i = 0; i < N; i++) trig(i, 5, 30);
    step(1'b0, "sat_start"); untrig();
    repeat (33) step(1'b0, "sat_all4");

    // two in phase (2e9, no clamp), then two opposite-phase channels cancel
    trig(0, 5, 40); trig(1, 5, 40); step(1'b0, "pair_start"); untrig();
    repeat (5) step(1'b0, "pair_same");
    trig(2, 5, 30); trig(3, 5, 30); step(1'b0, "opp_start"); untrig();
    repeat (36) step(1'b0, "opp_cancel");

    // silent channel still runs its duration, alongside a fast tone
    trig(2, 0, 5); trig(3, 1, 8); step(1'b0, "silent_start"); untrig();
    repeat (9) step(1'b0, "silent_run");

    // handshake and output clamping with a held positive then negative mix
    trig(0, 20, 120); step(1'b0, "hs_tone_start"); untrig();
    step(1'b0, "hs_tone_wait");
    for (int r = 4; r < 6; r++) apply_row(r, "hs_pos_mix");
    quiet_inputs();
    repeat (20) step(1'b0, "hs_tone_wait");
    for (int r = 6; r < 10; r++) apply_row(r, "hs_neg_mix");
    audio_in_available = 1'b0; audio_out_allowed = 1'b0;
    left_channel_audio_in = 32'sd4242; right_channel_audio_in = -32'sd7;
    step(1'b0, "pre_reset_play");

    // asynchronous reset mid-play silences everything before the next edge
    reset = 1'b1;
    for (int i = 0; i < N; i++) sch[i] = 1'b0;
    prev_sum = 0;
    #2;
    e.nm = "reset_async"; e.l = exp_out(left_channel_audio_in, 32'sd0);
    e.r = exp_out(right_channel_audio_in, 32'sd0); e.strobe = 1'b0; e.act = '0;
    sbq.push_back(e); check();
    step(1'b0, "reset_held");
    reset = 1'b0;
    trig(0, 7, 0); step(1'b0, "post_reset_dur0"); untrig();
    repeat (4) step(1'b0, "post_reset_idle");

    if (sbq.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
